// File: rtl/ap_pkg.sv
// Shared constants, feeder state encoding and beat-count sizing helpers for the
// AP window feeder and its address generator.
package ap_pkg;

    localparam int CELL_BIT   = 8;
    localparam int N_CELL     = 9;
    localparam int N_CORE     = 8;
    localparam int BIASPORT   = 16;
    localparam int KERN_BYTES = 16;
    localparam int KERN_HALF  = 8;
    localparam int WIN_COLS   = 4;

    localparam int IN_W = CELL_BIT * N_CELL;
    localparam int WT_W = IN_W * N_CORE;
    localparam int BS_W = BIASPORT * N_CORE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } feed_state_e;

    // Beats per frame: every pool output needs four quad windows of two phases.
    function automatic int beat_total(input int img_w, input int img_h);
        return ((img_h - 3) / 2) * ((img_w - 3) / 2) * 8;
    endfunction

    function automatic int beat_cnt_width(input int img_w, input int img_h);
        return $clog2(beat_total(img_w, img_h) + 1);
    endfunction

endpackage

// File: rtl/ap_window_feeder_if.sv
// Bus bundle between the feeder and its surroundings: frame control, pixel
// stream, weight/bias bank writes and the AP-side beat outputs.
interface ap_window_feeder_if;
    import ap_pkg::*;

    logic                start;
    logic [2:0]          cfg_bound_level;
    logic [2:0]          cfg_step;
    logic                cfg_relu;
    logic                cfg_mp;
    logic                pix_valid;
    logic                pix_ready;
    logic [CELL_BIT-1:0] pix_data;
    logic                wb_we;
    logic                wb_is_bias;
    logic [6:0]          wb_addr;
    logic [15:0]         wb_data;
    logic [IN_W-1:0]     ap_in;
    logic [WT_W-1:0]     ap_weight;
    logic [BS_W-1:0]     ap_bias;
    logic                ap_en;
    logic                ap_en_relu;
    logic                ap_en_mp;
    logic [2:0]          ap_bound_level;
    logic [2:0]          ap_step;
    logic                busy;
    logic                done;

    modport master (
        output start, cfg_bound_level, cfg_step, cfg_relu, cfg_mp,
        output pix_valid, pix_data, wb_we, wb_is_bias, wb_addr, wb_data,
        input  pix_ready, ap_in, ap_weight, ap_bias, ap_en, ap_en_relu, ap_en_mp,
        input  ap_bound_level, ap_step, busy, done
    );

    modport slave (
        input  start, cfg_bound_level, cfg_step, cfg_relu, cfg_mp,
        input  pix_valid, pix_data, wb_we, wb_is_bias, wb_addr, wb_data,
        output pix_ready, ap_in, ap_weight, ap_bias, ap_en, ap_en_relu, ap_en_mp,
        output ap_bound_level, ap_step, busy, done
    );

endinterface

// File: rtl/ap_feed_addr_gen.sv
// Nested pool-row / pool-col / quad / phase counters that walk the window
// sequence in maxpool-quad order and flag the final beat of a frame.
module ap_feed_addr_gen
    import ap_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          adv_i,
    output logic [RW-1:0] r_o,
    output logic [CW-1:0] c_o,
    output logic          phase_o,
    output logic          last_o
);

    localparam int PW    = (IMG_W - 3) / 2;
    localparam int PH    = (IMG_H - 3) / 2;
    localparam int PIW   = $clog2(PH + 1);
    localparam int PJW   = $clog2(PW + 1);
    localparam int TOTAL = beat_total(IMG_W, IMG_H);
    localparam int BW    = beat_cnt_width(IMG_W, IMG_H);

    logic [PIW-1:0] pi_q, pi_d;
    logic [PJW-1:0] pj_q, pj_d;
    logic [1:0]     quad_q, quad_d;
    logic           phase_q, phase_d;
    logic [BW-1:0]  beat_q, beat_d;

    assign last_o  = (beat_q == BW'(TOTAL - 1));
    assign phase_o = phase_q;
    // Phase 1 reads the two rows below phase 0, so it adds two to the row.
    assign r_o = RW'({pi_q, 1'b0}) + RW'(quad_q[1]) + RW'({phase_q, 1'b0});
    assign c_o = CW'({pj_q, 1'b0}) + CW'(quad_q[0]);

    always_comb begin
        pi_d    = pi_q;
        pj_d    = pj_q;
        quad_d  = quad_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        if (clear_i) begin
            pi_d    = '0;
            pj_d    = '0;
            quad_d  = 2'd0;
            phase_d = 1'b0;
            beat_d  = '0;
        end else if (adv_i) begin
            beat_d = last_o ? '0 : beat_q + BW'(1);
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (quad_q != 2'd3) begin
                    quad_d = quad_q + 2'd1;
                end else begin
                    quad_d = 2'd0;
                    if (pj_q != PJW'(PW - 1)) begin
                        pj_d = pj_q + PJW'(1);
                    end else begin
                        pj_d = '0;
                        pi_d = (pi_q == PIW'(PH - 1)) ? '0 : pi_q + PIW'(1);
                    end
                end
            end
        end else begin
            beat_d = beat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pi_q    <= '0;
            pj_q    <= '0;
            quad_q  <= 2'd0;
            phase_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            pi_q    <= pi_d;
            pj_q    <= pj_d;
            quad_q  <= quad_d;
            phase_q <= phase_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/ap_window_feeder.sv
// AP input feeder: buffers one feature map, then streams 2x4 windows as two-phase
// beats with kernel halves and bias. `AP_FEED_HALVE_EN stores pixels halved.
module ap_window_feeder
    import ap_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              reset,
    ap_window_feeder_if.slave bus
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PXW  = $clog2(NPIX);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);

    feed_state_e         state_q, state_d;
    logic [PXW-1:0]      pcnt_q, pcnt_d;
    logic [CELL_BIT-1:0] px_q   [NPIX];
    logic [CELL_BIT-1:0] wt_q   [N_CORE][KERN_BYTES];
    logic [BIASPORT-1:0] bias_q [N_CORE];

    logic [2:0] cfg_bl_q, cfg_bl_d, cfg_step_q, cfg_step_d;
    logic       cfg_relu_q, cfg_relu_d, cfg_mp_q, cfg_mp_d;

    logic [IN_W-1:0] ap_in_q, ap_in_d;
    logic [WT_W-1:0] ap_wt_q, ap_wt_d;
    logic [BS_W-1:0] ap_bs_q, ap_bs_d;
    logic            ap_en_q, ap_en_d, ap_relu_q, ap_relu_d, ap_mp_q, ap_mp_d;
    logic [2:0]      ap_bl_q, ap_bl_d, ap_step_q, ap_step_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic                start_s, wb_fire_s, pix_fire_s, pix_last_s;
    logic [CELL_BIT-1:0] pix_store_s;
    logic [RW-1:0]       ag_r_s;
    logic [CW-1:0]       ag_c_s;
    logic                ag_phase_s, ag_last_s;
    logic [PXW-1:0]      base_s;
    logic [IN_W-1:0]     beat_in_s;
    logic [WT_W-1:0]     beat_wt_s;
    logic [BS_W-1:0]     beat_bs_s;

    assign start_s    = (state_q == ST_IDLE) && bus.start;
    assign wb_fire_s  = (state_q == ST_IDLE) && bus.wb_we;
    assign pix_fire_s = (state_q == ST_LOAD) && bus.pix_valid;
    assign pix_last_s = pix_fire_s && (pcnt_q == PXW'(NPIX - 1));

`ifdef AP_FEED_HALVE_EN
    assign pix_store_s = {1'b0, bus.pix_data[CELL_BIT-1:1]};
`else
    assign pix_store_s = bus.pix_data;
`endif

    ap_feed_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RW    (RW),
        .CW    (CW)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != ST_RUN),
        .adv_i   (state_q == ST_RUN),
        .r_o     (ag_r_s),
        .c_o     (ag_c_s),
        .phase_o (ag_phase_s),
        .last_o  (ag_last_s)
    );

    assign base_s = PXW'(int'(ag_r_s) * IMG_W + int'(ag_c_s));

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                pcnt_d  = '0;
                state_d = start_s ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                pcnt_d  = pix_fire_s ? pcnt_q + PXW'(1) : pcnt_q;
                state_d = pix_last_s ? ST_RUN : ST_LOAD;
            end
            ST_RUN: begin
                state_d = ag_last_s ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core 0 and the top-left pixel occupy the MSBs of every bus.
    always_comb begin
        beat_in_s = '0;
        beat_wt_s = '0;
        beat_bs_s = '0;
        for (int j = 0; j < WIN_COLS; j++) begin
            beat_in_s[IN_W-1-CELL_BIT*j -: CELL_BIT]              = px_q[base_s + PXW'(j)];
            beat_in_s[IN_W-1-CELL_BIT*(j+WIN_COLS) -: CELL_BIT]   = px_q[base_s + PXW'(IMG_W + j)];
        end
        for (int n = 0; n < N_CORE; n++) begin
            for (int k = 0; k < KERN_HALF; k++) begin
                beat_wt_s[WT_W-1-n*IN_W-CELL_BIT*k -: CELL_BIT] = wt_q[n][{ag_phase_s, 3'(k)}];
            end
            if (!ag_phase_s) begin
                beat_bs_s[BS_W-1-n*BIASPORT -: BIASPORT] = bias_q[n];
            end else begin
                beat_bs_s[BS_W-1-n*BIASPORT -: BIASPORT] = '0;
            end
        end
    end

    always_comb begin
        ap_in_d = '0;
        ap_wt_d = '0;
        ap_bs_d = '0;
        ap_en_d = 1'b0;
        if (state_q == ST_RUN) begin
            ap_in_d = beat_in_s;
            ap_wt_d = beat_wt_s;
            ap_bs_d = beat_bs_s;
            ap_en_d = 1'b1;
        end else begin
            ap_en_d = 1'b0;
        end
        done_d = (state_q == ST_DONE);
        busy_d = (state_d != ST_IDLE) || done_d;
        if (start_s) begin
            cfg_bl_d   = bus.cfg_bound_level;
            cfg_step_d = bus.cfg_step;
            cfg_relu_d = bus.cfg_relu;
            cfg_mp_d   = bus.cfg_mp;
        end else begin
            cfg_bl_d   = cfg_bl_q;
            cfg_step_d = cfg_step_q;
            cfg_relu_d = cfg_relu_q;
            cfg_mp_d   = cfg_mp_q;
        end
        // Control outputs carry the frame config for the whole busy window.
        if (busy_d) begin
            ap_bl_d   = cfg_bl_d;
            ap_step_d = cfg_step_d;
            ap_relu_d = cfg_relu_d;
            ap_mp_d   = cfg_mp_d;
        end else begin
            ap_bl_d   = 3'd0;
            ap_step_d = 3'd0;
            ap_relu_d = 1'b0;
            ap_mp_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NPIX; i++) begin
                px_q[i] <= '0;
            end
        end else if (pix_fire_s) begin
            px_q[pcnt_q] <= pix_store_s;
        end
    end

    // The 7-bit address spans exactly N_CORE*16 weight bytes, so only bias needs a range check.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < N_CORE; n++) begin
                bias_q[n] <= '0;
                for (int k = 0; k < KERN_BYTES; k++) begin
                    wt_q[n][k] <= '0;
                end
            end
        end else if (wb_fire_s) begin
            if (bus.wb_is_bias) begin
                if (bus.wb_addr < 7'(N_CORE)) begin
                    bias_q[bus.wb_addr[2:0]] <= bus.wb_data;
                end
            end else begin
                wt_q[bus.wb_addr[6:4]][bus.wb_addr[3:0]] <= bus.wb_data[CELL_BIT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_bl_q   <= 3'd0;
            cfg_step_q <= 3'd0;
            cfg_relu_q <= 1'b0;
            cfg_mp_q   <= 1'b0;
            ap_in_q    <= '0;
            ap_wt_q    <= '0;
            ap_bs_q    <= '0;
            ap_en_q    <= 1'b0;
            ap_relu_q  <= 1'b0;
            ap_mp_q    <= 1'b0;
            ap_bl_q    <= 3'd0;
            ap_step_q  <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cfg_bl_q   <= cfg_bl_d;
            cfg_step_q <= cfg_step_d;
            cfg_relu_q <= cfg_relu_d;
            cfg_mp_q   <= cfg_mp_d;
            ap_in_q    <= ap_in_d;
            ap_wt_q    <= ap_wt_d;
            ap_bs_q    <= ap_bs_d;
            ap_en_q    <= ap_en_d;
            ap_relu_q  <= ap_relu_d;
            ap_mp_q    <= ap_mp_d;
            ap_bl_q    <= ap_bl_d;
            ap_step_q  <= ap_step_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.pix_ready      = (state_q == ST_LOAD);
    assign bus.ap_in          = ap_in_q;
    assign bus.ap_weight      = ap_wt_q;
    assign bus.ap_bias        = ap_bs_q;
    assign bus.ap_en          = ap_en_q;
    assign bus.ap_en_relu     = ap_relu_q;
    assign bus.ap_en_mp       = ap_mp_q;
    assign bus.ap_bound_level = ap_bl_q;
    assign bus.ap_step        = ap_step_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_ap_window_feeder.sv
// Random-frame bench for ap_window_feeder: expected beats come from a reference
// model that decodes the beat index with plain division into a window position.
module tb_ap_window_feeder;
    import ap_pkg::*;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int NPIX  = W * H;
    localparam int PW    = (W - 3) / 2;
    localparam int PH    = (H - 3) / 2;
    localparam int NBEAT = PH * PW * 8;

    logic clk;
    logic reset;

    ap_window_feeder_if bus_if ();

    ap_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_raw [NPIX];
    logic [7:0]  m_w   [N_CORE][KERN_BYTES];
    logic [15:0] m_b   [N_CORE];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef AP_FEED_HALVE_EN
        return d >> 1;
`else
        return d;
`endif
    endfunction

    function automatic logic [71:0] exp_in(input int b);
        int ph, qd, pj, pi, r, c;
        logic [71:0] v;
        ph = b % 2;
        qd = (b / 2) % 4;
        pj = (b / 8) % PW;
        pi = b / (8 * PW);
        r  = 2 * pi + qd / 2 + 2 * ph;
        c  = 2 * pj + qd % 2;
        v  = '0;
        for (int row = 0; row < 2; row++)
            for (int j = 0; j < 4; j++)
                v = (v << 8) | 72'(stored(m_raw[(r + row) * W + c + j]));
        return v << 8;
    endfunction

    function automatic logic [575:0] exp_wt(input int b);
        logic [575:0] v;
        v = '0;
        for (int n = 0; n < N_CORE; n++) begin
            for (int k = 0; k < 8; k++) v = (v << 8) | 576'(m_w[n][8 * (b % 2) + k]);
            v = v << 8;
        end
        return v;
    endfunction

    function automatic logic [127:0] exp_bs(input int b);
        logic [127:0] v;
        v = '0;
        for (int n = 0; n < N_CORE; n++) v = (v << 16) | ((b % 2 == 0) ? 128'(m_b[n]) : 128'd0);
        return v;
    endfunction

    task automatic clear_model_banks();
        for (int n = 0; n < N_CORE; n++) begin
            m_b[n] = 16'd0;
            for (int k = 0; k < KERN_BYTES; k++) m_w[n][k] = 8'd0;
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic wb_write(input logic isb, input int a, input logic [15:0] d);
        bus_if.wb_we      = 1'b1;
        bus_if.wb_is_bias = isb;
        bus_if.wb_addr    = 7'(a);
        bus_if.wb_data    = d;
        @(negedge clk);
        bus_if.wb_we = 1'b0;
        if (isb) begin
            if (a < N_CORE) m_b[a] = d;
        end else begin
            m_w[a / 16][a % 16] = d[7:0];
        end
    endtask

    task automatic do_frame(input int abort_at, input logic [2:0] bl, input logic [2:0] st,
                            input logic relu, input logic mp, input bit known);
        int idx, guard, n_en;
        logic acc;
        logic [15:0] nb1;
        nb1 = 16'($urandom);
        bus_if.start = 1'b1;
        bus_if.cfg_bound_level = bl;
        bus_if.cfg_step = st;
        bus_if.cfg_relu = relu;
        bus_if.cfg_mp = mp;
        bus_if.wb_we = 1'b1;
        bus_if.wb_is_bias = 1'b1;
        bus_if.wb_addr = 7'd1;
        bus_if.wb_data = nb1;
        m_b[1] = nb1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.wb_we = 1'b0;
        check("load_busy", bus_if.busy, 1'b1);
        check("load_ready", bus_if.pix_ready, 1'b1);
        idx = 0;
        guard = 0;
        while (idx < NPIX && guard < 20000) begin
            bus_if.pix_valid = ($urandom_range(0, 3) != 0);
            bus_if.pix_data  = m_raw[idx];
            if (idx == 100) begin
                bus_if.start = 1'b1;
                bus_if.cfg_bound_level = ~bl;
                bus_if.cfg_step = ~st;
                bus_if.cfg_relu = ~relu;
                bus_if.cfg_mp = ~mp;
                bus_if.wb_we = 1'b1;
                bus_if.wb_is_bias = 1'b0;
                bus_if.wb_addr = 7'd0;
                bus_if.wb_data = 16'h00EE;
            end else begin
                bus_if.start = 1'b0;
                bus_if.wb_we = 1'b0;
            end
            acc = bus_if.pix_valid && bus_if.pix_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        bus_if.pix_valid = 1'b0;
        bus_if.start = 1'b0;
        bus_if.wb_we = 1'b0;
        if (idx != NPIX) begin
            check("load_timeout", 32'(idx), 32'(NPIX));
            return;
        end
        check("pre_beat_en", bus_if.ap_en, 1'b0);
        n_en = 0;
        for (int b = 0; b < NBEAT; b++) begin
            @(negedge clk);
            if (bus_if.ap_en) n_en++;
            bus_if.wb_we = 1'b0;
            check("beat_en", bus_if.ap_en, 1'b1);
            check("beat_in", bus_if.ap_in, exp_in(b));
            check("beat_wt", bus_if.ap_weight, exp_wt(b));
            check("beat_bs", bus_if.ap_bias, exp_bs(b));
            if (b == 0) check("ctrl", {bus_if.ap_en_relu, bus_if.ap_en_mp, bus_if.ap_bound_level, bus_if.ap_step, bus_if.busy},
                              {relu, mp, bl, st, 1'b1});
`ifndef AP_FEED_HALVE_EN
            if (known && b == 0) begin
                check("k_in0", bus_if.ap_in, 72'h000102031C1D1E1F00);
                check("k_wt0", bus_if.ap_weight[575:504], 72'h010203040506070800);
                check("k_bs0", bus_if.ap_bias[127:112], 16'h0010);
            end
            if (known && b == 1) begin
                check("k_in1", bus_if.ap_in, 72'h38393A3B5455565700);
                check("k_bs1", bus_if.ap_bias[127:112], 16'h0000);
            end
            if (known && b == 2) check("k_in2", bus_if.ap_in[71:64], 8'h01);
            if (known && b == 4) check("k_in4", bus_if.ap_in[71:64], 8'h1C);
            if (known && b == 6) check("k_in6", bus_if.ap_in[71:64], 8'h1D);
            if (known && b == 8) check("k_in8", bus_if.ap_in[71:64], 8'h02);
`else
            if (b == 0 && m_raw[0] == 8'hFF) check("halve_ff", bus_if.ap_in[71:64], 8'h7F);
`endif
            if (b == 300) begin
                bus_if.wb_we = 1'b1;
                bus_if.wb_is_bias = 1'b0;
                bus_if.wb_addr = 7'd8;
                bus_if.wb_data = 16'h00A5;
            end
            if (b == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_ctrl", {bus_if.ap_en, bus_if.ap_en_relu, bus_if.ap_en_mp, bus_if.ap_bound_level,
                                     bus_if.ap_step, bus_if.busy, bus_if.done, bus_if.pix_ready}, 12'd0);
                check("abort_in", bus_if.ap_in, 72'd0);
                check("abort_wt", bus_if.ap_weight, 576'd0);
                check("abort_bs", bus_if.ap_bias, 128'd0);
                reset = 1'b1;
                clear_model_banks();
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_nodone", {bus_if.done, bus_if.busy, bus_if.ap_en}, 3'd0);
                end
                return;
            end
        end
        @(negedge clk);
        check("done_hi", {bus_if.done, bus_if.ap_en, bus_if.busy}, 3'b101);
        check("done_in0", bus_if.ap_in, 72'd0);
        check("done_wt0", bus_if.ap_weight, 576'd0);
        check("done_bs0", bus_if.ap_bias, 128'd0);
        check("en_count", 32'(n_en), 32'(NBEAT));
        @(negedge clk);
        check("after_done", {bus_if.done, bus_if.busy, bus_if.ap_en}, 3'd0);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        bus_if.start = 1'b0;
        bus_if.cfg_bound_level = 3'd0;
        bus_if.cfg_step = 3'd0;
        bus_if.cfg_relu = 1'b0;
        bus_if.cfg_mp = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data = 8'd0;
        bus_if.wb_we = 1'b0;
        bus_if.wb_is_bias = 1'b0;
        bus_if.wb_addr = 7'd0;
        bus_if.wb_data = 16'd0;
        clear_model_banks();
        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus_if.ap_en, bus_if.ap_en_relu, bus_if.ap_en_mp, bus_if.ap_bound_level,
                           bus_if.ap_step, bus_if.busy, bus_if.done, bus_if.pix_ready}, 12'd0);
        check("rst_in", bus_if.ap_in, 72'd0);
        check("rst_wt", bus_if.ap_weight, 576'd0);
        check("rst_bs", bus_if.ap_bias, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // Frame A: ramp pixels, ramp kernel on core 0, plus ignored bias writes.
        for (int n = 0; n < N_CORE; n++)
            for (int k = 0; k < KERN_BYTES; k++)
                wb_write(1'b0, n * 16 + k, {8'($urandom), (n == 0) ? 8'(k + 1) : 8'($urandom)});
        for (int n = 0; n < N_CORE; n++) wb_write(1'b1, n, (n == 0) ? 16'h0010 : 16'($urandom));
        wb_write(1'b1, 9, 16'hDEAD);
        wb_write(1'b1, 127, 16'hBEEF);
        for (int i = 0; i < NPIX; i++) m_raw[i] = 8'(i % 256);
        do_frame(-1, 3'd5, 3'd2, 1'b1, 1'b0, 1'b1);

        // Frame B: random data, aborted by reset mid-run.
        for (int i = 0; i < NPIX; i++) m_raw[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) wb_write(1'b0, $urandom_range(0, 127), 16'($urandom));
        do_frame(500, 3'($urandom), 3'($urandom), 1'b0, 1'b1, 1'b0);

        // Frame C: banks were cleared, refill only cores 0..3.
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < KERN_BYTES; k++) wb_write(1'b0, n * 16 + k, 16'($urandom));
            wb_write(1'b1, n, 16'($urandom));
        end
        for (int i = 0; i < NPIX; i++) m_raw[i] = 8'($urandom);
        m_raw[0] = 8'hFF;
        do_frame(-1, 3'($urandom), 3'($urandom), 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/ap_window_feeder.md
# ap_window_feeder

Hardware feeder that drives the AP accelerator's input interface (`in`, `weight`, `bias`, `en`, control) for one conv4x4 + ReLU + 2x2-maxpool layer. It buffers one input feature map, then streams 2x4 pixel windows as two-phase beats with the matching kernel halves and bias, in maxpool-quad order. It sits between the feature-map source (DMA/line loader) and `AP`, replacing software window generation.

## Interface
- `CELL_BIT`, 8, pixel/weight byte width
- `N_CELL`, 9, cells per AP core (8 used + 1 zero pad)
- `N_CORE`, 8, AP cores
- `BIASPORT`, 16, bias width per core
- `IMG_W`, 28, map width (even, >=6)
- `IMG_H`, 28, map height (even, >=6)
- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-low
- `start` in 1 — begin frame (sampled in IDLE only)
- `cfg_bound_level` in 3, `cfg_step` in 3, `cfg_relu` in 1, `cfg_mp` in 1 — latched on `start`
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in 8 — raster-order pixel stream
- `wb_we` in 1, `wb_is_bias` in 1, `wb_addr` in 7, `wb_data` in 16 — weight/bias bank write
- `ap_in` out CELL_BIT*N_CELL, `ap_weight` out CELL_BIT*N_CELL*N_CORE, `ap_bias` out BIASPORT*N_CORE
- `ap_en`, `ap_en_relu`, `ap_en_mp` out 1; `ap_bound_level`, `ap_step` out 3
- `busy` out 1, `done` out 1

## Operation
- States: IDLE → (start) LOAD → (last pixel accepted) RUN → (last beat) DONE → IDLE.
- IDLE: `wb_we` writes banks; weight byte addr = core*16+k (k 0..15, data[7:0]), bias addr = core (data[15:0]); out-of-range addr ignored. Writes outside IDLE ignored.
- LOAD: `pix_ready`=1; each handshake stores pixel at next raster position; IMG_W*IMG_H pixels total.
- RUN: PW=(IMG_W-3)/2, PH=(IMG_H-3)/2 pool outputs. Loop pi 0..PH-1, pj 0..PW-1, quad (dy,dx) in order (0,0),(0,1),(1,0),(1,1), phase p 0..1: r=2pi+dy+2p, c=2pj+dx.
- Beat: `ap_in` = {px[r][c..c+3], px[r+1][c..c+3], 8'h00}, first byte in MSBs.
- Core n slice of `ap_weight` at bits [top−n*72 −:72] = phase 0: {w[n][0..7], 8'h00}; phase 1: {w[n][8..15], 8'h00}.
- Core n `ap_bias` slice [top−n*16 −:16] = bias[n] in phase 0, 0 in phase 1.
- Total beats = PH*PW*8 (1152 at 28x28).
- Control outputs reflect latched cfg from LOAD through DONE; `busy`=1 in LOAD/RUN/DONE.

## Timing
- Reset: state IDLE, all outputs 0, pixel and weight/bias banks cleared to 0; reset mid-frame aborts with no `done`.
- Last pixel accepted at edge E: beat 0 registered at E+1; `ap_en`=1 for exactly PH*PW*8 consecutive cycles, one beat per cycle, no stalls.
- `done`=1 for one cycle, the cycle after final beat; `ap_en`=0 that cycle with data outputs zeroed.
- `start` while busy ignored. `pix_valid` outside LOAD ignored. `start` and `wb_we` in same IDLE cycle: write commits, then LOAD.

## Configuration
- `AP_FEED_HALVE_EN` defined: pixel stored as `pix_data >> 1` (logical, MSB 0), keeping inputs non-negative in signed AP cells.
- Undefined: stored unmodified.

## Structure
- Shared package `ap_pkg`: CELL_BIT, N_CELL, N_CORE, BIASPORT constants, feeder state enum, beat-count width function.
- One sub-module `ap_feed_addr_gen`: nested pi/pj/quad/phase counters producing r, c, phase, last-beat flag.

## Test plan
- Pixel[i]=i mod 256, no macro, w[0][k]=k+1, bias[0]=16'h0010 → beat 0: `ap_in`=00010203_1C1D1E1F_00, core0 weight=0102…08_00, bias0=0010; beat 1: `ap_in`=38393A3B_5455565_700 (rows 2,3), bias0=0.
- Same frame → beats 2/4/6 start at columns/rows (0,1),(1,0),(1,1); beat 8 starts at px[0][2].
- Count `ap_en` cycles → exactly 1152, contiguous; `done` one cycle after last, `busy` low next.
- `AP_FEED_HALVE_EN`, pixel 8'hFF → `ap_in` byte 8'h7F.
- Reset low during RUN beat 500 → next cycle all outputs 0, IDLE, no `done`; fresh `start` reloads correctly.
- `wb_we` during RUN, `start` during LOAD → ignored, banks and beat sequence unchanged.
